layered_palette_mapper: RTL and testbench
=========================================

// Module: layered_palette_mapper
// PURPOSE
//  Pipelined pixel compositor between sprite/tile fetch units and the VGA DAC. Picks the
//  highest-priority opaque layer index per pixel (falls back to background) and maps it
//  through a run-time writable palette RAM to 8:8:8 RGB. Also reports per-pixel and
//  per-frame sprite overlap against layer 0 (player) for game logic.
// PARAMETERS
//  NUM_LAYERS   4   sprite layers; layer 0 = highest priority
//  IDX_W        5   palette index width; palette depth = 2**IDX_W
//  TRANSP_IDX   0   index value treated as transparent on every sprite layer
// PORTS
//  Clk            in   1               system clock (one clock domain)
//  Reset          in   1               synchronous, active-high
//  pix_valid_in   in   1               DrawX/DrawY/layer inputs valid this cycle
//  blank_in       in   1               1 = outside active video; forces black
//  DrawX, DrawY   in   10 each         pixel coordinates, passed down the pipeline
//  layer_hit      in   NUM_LAYERS      bit i: pixel lies inside sprite i bounding box
//  layer_idx      in   NUM_LAYERS*IDX_W  layer i index at [i*IDX_W +: IDX_W]
//  layer_en       in   NUM_LAYERS      bit i: layer i enabled (quasi-static)
//  bg_idx         in   IDX_W           background palette index (never transparent)
//  frame_start    in   1               1-cycle pulse; clears collision sticky bits
//  pal_we         in   1               palette write strobe
//  pal_waddr      in   IDX_W           palette write address
//  pal_wdata      in   24              RGB 8:8:8 write data {R,G,B}
//  pal_busy       out  1               1 while the post-reset init sweep runs
//  pix_valid_out  out  1               outputs below valid
//  DrawX_out, DrawY_out  out 10 each   coordinates aligned with the RGB output
//  VGA_R, VGA_G, VGA_B   out 8 each    pixel colour
//  collide_out    out  NUM_LAYERS      per-pixel overlap mask, aligned with the RGB output
//  collide_sticky out  NUM_LAYERS      OR of collide_out since the last frame_start
// BEHAVIOUR
//  Reset: all outputs 0, pipeline valids cleared, collide_sticky 0, pal_busy=1 on the
//   next cycle, init counter = 0. Reset mid-frame or mid-init restarts init from entry 0.
//  Init FSM IDLE->INIT->RUN: INIT writes 24'h000000 to one entry per cycle, 0..2**IDX_W-1.
//   Leaves INIT after the last entry. pal_busy=1 for exactly 2**IDX_W cycles.
//   pal_we is ignored while pal_busy=1.
//  Opaque(i) = layer_en[i] & layer_hit[i] & (layer_idx[i] != TRANSP_IDX).
//  Stage 1 (registered): sel = layer_idx of the lowest i with Opaque(i), else bg_idx.
//   Mask m = Opaque vector. blank, valid and coordinates are registered alongside.
//  Stage 2: synchronous palette read at sel. A write to the same address in the same cycle
//   returns the OLD data (read-before-write). The write is visible to reads one cycle later.
//  Stage 3: output registers. RGB = blank ? 0 : palette data.
//   collide_out[i] = m[0] & m[i] for i>=1; collide_out[0] = m[0] & |m[NUM_LAYERS-1:1].
//  Latency: exactly 3 Clk cycles from pix_valid_in to pix_valid_out. Throughput 1 px/clk.
//   No stall. Bubbles propagate: when valid=0, RGB holds its previous value.
//  collide_sticky: updated only on cycles with pix_valid_out=1.
//   With frame_start=1 in a cycle: sticky <= collide_out of that cycle (clear, then OR).
//   Otherwise: sticky <= sticky | collide_out.
//  While pal_busy=1: pipeline still runs and outputs black (palette holds zeros).
//  blank_in=1 also forces collide_out to 0.
// TESTING
//  1. Reset 1 cycle -> pal_busy high for 32 cycles, then low; all outputs 0 during Reset.
//  2. Write idx5=24'h570C0C. Pixel with bg_idx=5, no hits, valid at cycle T -> at T+3:
//     R=57, G=0C, B=0C, pix_valid_out=1, DrawX/DrawY_out equal to the inputs.
//  3. Layers 0 and 2 hit with idx 0 and 7, bg 3 -> colour of idx7 (layer 0 is transparent).
//     collide_out=0.
//  4. Layers 0 and 1 opaque (idx 6 and 9) -> colour of idx6; collide_out=4'b0011;
//     sticky stays set until frame_start. frame_start on a no-overlap pixel -> sticky=0.
//  5. pal_we to idx 4 in the same cycle that idx 4 is read -> old colour returned.
//     The next read returns the new colour.
//  6. Assert Reset during a pixel stream and during init -> valids drop to 0 the next
//     cycle; init restarts at 0 for 32 cycles; earlier writes lost.

Source files
------------

// File: rtl/lpm_if.sv
// Pixel, palette-write and RGB output bundle between the fetch units, the compositor and the DAC.
interface lpm_if #(
    parameter int unsigned NUM_LAYERS = 4,
    parameter int unsigned IDX_W      = 5
);
    logic                        pix_valid_in;
    logic                        blank_in;
    logic [9:0]                  DrawX;
    logic [9:0]                  DrawY;
    logic [NUM_LAYERS-1:0]       layer_hit;
    logic [NUM_LAYERS*IDX_W-1:0] layer_idx;
    logic [NUM_LAYERS-1:0]       layer_en;
    logic [IDX_W-1:0]            bg_idx;
    logic                        frame_start;
    logic                        pal_we;
    logic [IDX_W-1:0]            pal_waddr;
    logic [23:0]                 pal_wdata;
    logic                        pal_busy;
    logic                        pix_valid_out;
    logic [9:0]                  DrawX_out;
    logic [9:0]                  DrawY_out;
    logic [7:0]                  VGA_R;
    logic [7:0]                  VGA_G;
    logic [7:0]                  VGA_B;
    logic [NUM_LAYERS-1:0]       collide_out;
    logic [NUM_LAYERS-1:0]       collide_sticky;

    modport master (
        output pix_valid_in, blank_in, DrawX, DrawY, layer_hit, layer_idx, layer_en, bg_idx,
               frame_start, pal_we, pal_waddr, pal_wdata,
        input  pal_busy, pix_valid_out, DrawX_out, DrawY_out, VGA_R, VGA_G, VGA_B,
               collide_out, collide_sticky
    );

    modport slave (
        input  pix_valid_in, blank_in, DrawX, DrawY, layer_hit, layer_idx, layer_en, bg_idx,
               frame_start, pal_we, pal_waddr, pal_wdata,
        output pal_busy, pix_valid_out, DrawX_out, DrawY_out, VGA_R, VGA_G, VGA_B,
               collide_out, collide_sticky
    );
endinterface

// File: rtl/layered_palette_mapper.sv
// Three-stage layer compositor: priority select, palette RAM lookup, RGB/collision output.
// The palette is zeroed by an init sweep after every reset.
module layered_palette_mapper #(
    parameter int unsigned NUM_LAYERS = 4,
    parameter int unsigned IDX_W      = 5,
    parameter int unsigned TRANSP_IDX = 0
) (
    input logic Clk,
    input logic Reset,
    lpm_if.slave bus
);
    localparam int unsigned DEPTH = 2**IDX_W;

    typedef enum logic [1:0] {IDLE, INIT, RUN} state_t;

    state_t                state;
    logic [IDX_W-1:0]      init_cnt;
    logic [23:0]           pal_mem [DEPTH];

    logic                  wr_en;
    logic [IDX_W-1:0]      wr_addr;
    logic [23:0]           wr_data;

    logic [NUM_LAYERS-1:0] opaque_c;
    logic [IDX_W-1:0]      sel_c;

    logic                  v1, b1;
    logic [9:0]            x1, y1;
    logic [IDX_W-1:0]      sel1;
    logic [NUM_LAYERS-1:0] m1;

    logic                  v2, b2;
    logic [9:0]            x2, y2;
    logic [NUM_LAYERS-1:0] m2;
    logic [23:0]           rd2;
    logic [NUM_LAYERS-1:0] coll_c;

    // Init sequencer: one zero write per cycle, then hand the RAM to the host port
    always_ff @(posedge Clk) begin
        if (Reset) begin
            state        <= IDLE;
            init_cnt     <= '0;
            bus.pal_busy <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    state        <= INIT;
                    init_cnt     <= '0;
                    bus.pal_busy <= 1'b1;
                end
                INIT: begin
                    init_cnt <= init_cnt + IDX_W'(1);
                    if (init_cnt == '1) begin
                        state        <= RUN;
                        bus.pal_busy <= 1'b0;
                    end
                end
                default: begin
                    state        <= RUN;
                    bus.pal_busy <= 1'b0;
                end
            endcase
        end
    end

    always_comb begin
        wr_en   = 1'b0;
        wr_addr = bus.pal_waddr;
        wr_data = bus.pal_wdata;
        if (state == INIT) begin
            wr_en   = 1'b1;
            wr_addr = init_cnt;
            wr_data = 24'h000000;
        end else if (state == RUN && bus.pal_we && !Reset) begin
            wr_en = 1'b1;
        end
    end

    // Read-before-write RAM; reads return black until the sweep has finished
    always_ff @(posedge Clk) begin
        if (wr_en) pal_mem[wr_addr] <= wr_data;
        rd2 <= (state == RUN) ? pal_mem[sel1] : 24'h000000;
    end

    always_comb begin
        opaque_c = '0;
        sel_c    = bus.bg_idx;
        for (int i = 0; i < NUM_LAYERS; i++)
            opaque_c[i] = bus.layer_en[i] & bus.layer_hit[i] &
                          (bus.layer_idx[i*IDX_W +: IDX_W] != IDX_W'(TRANSP_IDX));
        for (int i = NUM_LAYERS - 1; i >= 0; i--)
            if (opaque_c[i]) sel_c = bus.layer_idx[i*IDX_W +: IDX_W];
    end

    always_comb begin
        coll_c    = '0;
        coll_c[0] = m2[0] & (|m2[NUM_LAYERS-1:1]);
        for (int i = 1; i < NUM_LAYERS; i++) coll_c[i] = m2[0] & m2[i];
        if (b2) coll_c = '0;
    end

    always_ff @(posedge Clk) begin
        if (Reset) begin
            v1 <= 1'b0; b1 <= 1'b0; x1 <= '0; y1 <= '0; sel1 <= '0; m1 <= '0;
            v2 <= 1'b0; b2 <= 1'b0; x2 <= '0; y2 <= '0; m2 <= '0;
            bus.pix_valid_out  <= 1'b0;
            bus.DrawX_out      <= '0;
            bus.DrawY_out      <= '0;
            bus.VGA_R          <= '0;
            bus.VGA_G          <= '0;
            bus.VGA_B          <= '0;
            bus.collide_out    <= '0;
            bus.collide_sticky <= '0;
        end else begin
            v1 <= bus.pix_valid_in; b1 <= bus.blank_in;
            x1 <= bus.DrawX; y1 <= bus.DrawY; sel1 <= sel_c; m1 <= opaque_c;
            v2 <= v1; b2 <= b1; x2 <= x1; y2 <= y1; m2 <= m1;
            bus.pix_valid_out <= v2;
            // Bubbles leave the previous pixel on the outputs
            if (v2) begin
                bus.DrawX_out   <= x2;
                bus.DrawY_out   <= y2;
                bus.VGA_R       <= b2 ? 8'h00 : rd2[23:16];
                bus.VGA_G       <= b2 ? 8'h00 : rd2[15:8];
                bus.VGA_B       <= b2 ? 8'h00 : rd2[7:0];
                bus.collide_out <= coll_c;
            end
            if (bus.pix_valid_out)
                bus.collide_sticky <= bus.frame_start ? bus.collide_out
                                                      : (bus.collide_sticky | bus.collide_out);
        end
    end
endmodule

// File: tb/tb_layered_palette_mapper.sv
// Directed table, corner sequences and random traffic against a cycle-level behavioural model.
module tb_layered_palette_mapper;
    localparam int unsigned NL = 4;
    localparam int unsigned IW = 5;

    logic clk = 1'b0;
    logic rst;
    lpm_if #(.NUM_LAYERS(NL), .IDX_W(IW)) bus();

    layered_palette_mapper #(.NUM_LAYERS(NL), .IDX_W(IW), .TRANSP_IDX(0)) dut (
        .Clk(clk), .Reset(rst), .bus(bus)
    );

    always #5 clk = ~clk;

    typedef struct { logic v; logic [9:0] x, y; logic [23:0] rgb; logic [3:0] coll; } exp_t;
    typedef struct {
        logic blank; logic [3:0] hit, en; logic [19:0] idx; logic [4:0] bg;
        logic [23:0] rgb; logic [3:0] coll;
    } vec_t;

    int n_cmp = 0;
    int n_bad = 0;

    logic [23:0] pal_m [32];
    int          rel;
    exp_t        pipe [2];
    logic        e_valid, e_busy;
    logic [9:0]  e_x, e_y;
    logic [23:0] e_rgb;
    logic [3:0]  e_coll, e_sticky;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Model the effect of one clock edge, then compare every output just after it
    task automatic step();
        exp_t       np;
        logic [4:0] sel, li;
        logic [3:0] m;
        logic       found;
        @(posedge clk);
        if (rst) begin
            for (int i = 0; i < 32; i++) pal_m[i] = 24'h0;
            rel = 0;
            pipe[0] = '{default: '0};
            pipe[1] = '{default: '0};
            e_valid = 0; e_x = 0; e_y = 0; e_rgb = 0; e_coll = 0; e_sticky = 0;
        end else begin
            if (e_valid) e_sticky = bus.frame_start ? e_coll : (e_sticky | e_coll);
            e_valid = pipe[0].v;
            if (pipe[0].v) begin
                e_x = pipe[0].x; e_y = pipe[0].y; e_rgb = pipe[0].rgb; e_coll = pipe[0].coll;
            end
            if (bus.pal_we && rel >= 33) pal_m[bus.pal_waddr] = bus.pal_wdata;
            if (rel < 40) rel++;
            np.v = bus.pix_valid_in; np.x = bus.DrawX; np.y = bus.DrawY;
            sel = bus.bg_idx; found = 0; m = 0;
            for (int i = 0; i < 4; i++) begin
                li = bus.layer_idx[i*5 +: 5];
                m[i] = bus.layer_en[i] && bus.layer_hit[i] && (li != 5'd0);
                if (m[i] && !found) begin sel = li; found = 1; end
            end
            np.rgb  = (bus.blank_in || rel <= 32) ? 24'h0 : pal_m[sel];
            np.coll = 4'b0;
            if (!bus.blank_in && m[0]) np.coll = {m[3], m[2], m[1], |m[3:1]};
            pipe[0] = pipe[1];
            pipe[1] = np;
        end
        e_busy = (rel >= 1 && rel <= 32);
        #1;
        chk("valid_out", 32'(bus.pix_valid_out), 32'(e_valid));
        chk("pal_busy", 32'(bus.pal_busy), 32'(e_busy));
        chk("rgb", {8'h0, bus.VGA_R, bus.VGA_G, bus.VGA_B}, 32'(e_rgb));
        chk("coords", {12'h0, bus.DrawX_out, bus.DrawY_out}, {12'h0, e_x, e_y});
        chk("collide_out", 32'(bus.collide_out), 32'(e_coll));
        chk("collide_sticky", 32'(bus.collide_sticky), 32'(e_sticky));
    endtask

    task automatic idle();
        bus.pix_valid_in = 0; bus.frame_start = 0; bus.pal_we = 0;
    endtask

    task automatic drive(input logic blank, input logic [9:0] x, y, input logic [3:0] hit, en,
                         input logic [19:0] idx, input logic [4:0] bg);
        bus.pix_valid_in = 1; bus.blank_in = blank; bus.DrawX = x; bus.DrawY = y;
        bus.layer_hit = hit; bus.layer_en = en; bus.layer_idx = idx; bus.bg_idx = bg;
    endtask

    // One pixel followed by bubbles until it reaches the outputs
    task automatic run_pix(input logic blank, input logic [9:0] x, y, input logic [3:0] hit, en,
                           input logic [19:0] idx, input logic [4:0] bg);
        drive(blank, x, y, hit, en, idx, bg);
        step(); idle(); step(); step();
    endtask

    task automatic pal_write(input logic [4:0] a, input logic [23:0] d);
        bus.pal_we = 1; bus.pal_waddr = a; bus.pal_wdata = d;
        step();
        bus.pal_we = 0;
    endtask

    task automatic busy_count(input logic poke, output int cnt);
        cnt = 0;
        for (int c = 0; c < 100; c++) begin
            if (poke && c == 5) begin bus.pal_we = 1; bus.pal_waddr = 5'd2; bus.pal_wdata = 24'hFFFFFF; end
            else bus.pal_we = 0;
            step();
            if (bus.pal_busy) cnt++;
            else if (cnt > 0) break;
        end
        bus.pal_we = 0;
    endtask

    vec_t tbl [10];
    int   bc;

    initial begin
        bus.pix_valid_in = 0; bus.blank_in = 0; bus.DrawX = 0; bus.DrawY = 0;
        bus.layer_hit = 0; bus.layer_idx = 0; bus.layer_en = 4'hF; bus.bg_idx = 0;
        bus.frame_start = 0; bus.pal_we = 0; bus.pal_waddr = 0; bus.pal_wdata = 0;
        rst = 1;
        step();
        chk("reset_valid", 32'(bus.pix_valid_out), 32'd0);
        chk("reset_busy", 32'(bus.pal_busy), 32'd0);
        chk("reset_rgb", {8'h0, bus.VGA_R, bus.VGA_G, bus.VGA_B}, 32'd0);
        rst = 0;
        busy_count(1'b1, bc);
        chk("init_busy_len", 32'(bc), 32'd32);
        run_pix(0, 10'd1, 10'd1, 4'h0, 4'hF, 20'h0, 5'd2);
        chk("write_during_busy_ignored", {8'h0, bus.VGA_R, bus.VGA_G, bus.VGA_B}, 32'd0);

        pal_write(5'd3, 24'h112233);
        pal_write(5'd5, 24'h570C0C);
        pal_write(5'd6, 24'hA0B0C0);
        pal_write(5'd7, 24'h0000FF);
        pal_write(5'd9, 24'hFF8000);
        pal_write(5'd4, 24'h010203);

        tbl[0] = '{0, 4'b0000, 4'hF, {5'd0, 5'd0, 5'd0, 5'd0}, 5'd5, 24'h570C0C, 4'b0000};
        tbl[1] = '{0, 4'b0101, 4'hF, {5'd0, 5'd7, 5'd0, 5'd0}, 5'd3, 24'h0000FF, 4'b0000};
        tbl[2] = '{0, 4'b0011, 4'hF, {5'd0, 5'd0, 5'd9, 5'd6}, 5'd3, 24'hA0B0C0, 4'b0011};
        tbl[3] = '{0, 4'b1011, 4'hF, {5'd3, 5'd0, 5'd9, 5'd6}, 5'd3, 24'hA0B0C0, 4'b1011};
        tbl[4] = '{0, 4'b0110, 4'hF, {5'd0, 5'd7, 5'd9, 5'd0}, 5'd3, 24'hFF8000, 4'b0000};
        tbl[5] = '{0, 4'b0011, 4'hD, {5'd0, 5'd0, 5'd9, 5'd6}, 5'd3, 24'hA0B0C0, 4'b0000};
        tbl[6] = '{1, 4'b0011, 4'hF, {5'd0, 5'd0, 5'd9, 5'd6}, 5'd3, 24'h000000, 4'b0000};
        tbl[7] = '{0, 4'b1000, 4'hF, {5'd3, 5'd0, 5'd0, 5'd0}, 5'd5, 24'h112233, 4'b0000};
        tbl[8] = '{0, 4'b1000, 4'hF, {5'd0, 5'd0, 5'd0, 5'd0}, 5'd5, 24'h570C0C, 4'b0000};
        tbl[9] = '{0, 4'b0001, 4'h0, {5'd0, 5'd0, 5'd0, 5'd6}, 5'd3, 24'h112233, 4'b0000};
        for (int k = 0; k < 10; k++) begin
            run_pix(tbl[k].blank, 10'(100 + k), 10'(200 + k), tbl[k].hit, tbl[k].en,
                    tbl[k].idx, tbl[k].bg);
            chk($sformatf("tbl%0d_valid", k), 32'(bus.pix_valid_out), 32'd1);
            chk($sformatf("tbl%0d_rgb", k), {8'h0, bus.VGA_R, bus.VGA_G, bus.VGA_B}, 32'(tbl[k].rgb));
            chk($sformatf("tbl%0d_coll", k), 32'(bus.collide_out), 32'(tbl[k].coll));
            chk($sformatf("tbl%0d_xy", k), {12'h0, bus.DrawX_out, bus.DrawY_out},
                {12'h0, 10'(100 + k), 10'(200 + k)});
        end

        // Sticky survives non-overlapping pixels until frame_start
        bus.frame_start = 1; step(); bus.frame_start = 0;
        run_pix(0, 10'd5, 10'd5, 4'b0011, 4'hF, {5'd0, 5'd0, 5'd9, 5'd6}, 5'd3);
        step();
        chk("sticky_set", 32'(bus.collide_sticky), 32'h3);
        run_pix(0, 10'd6, 10'd5, 4'b0000, 4'hF, 20'h0, 5'd3);
        step();
        chk("sticky_hold", 32'(bus.collide_sticky), 32'h3);
        run_pix(0, 10'd7, 10'd5, 4'b0000, 4'hF, 20'h0, 5'd3);
        bus.frame_start = 1; step(); bus.frame_start = 0;
        chk("sticky_clear", 32'(bus.collide_sticky), 32'h0);

        // Write racing a read of the same entry
        drive(0, 10'd1, 10'd9, 4'h0, 4'hF, 20'h0, 5'd4);
        step();
        drive(0, 10'd2, 10'd9, 4'h0, 4'hF, 20'h0, 5'd4);
        bus.pal_we = 1; bus.pal_waddr = 5'd4; bus.pal_wdata = 24'h0A0B0C;
        step();
        idle();
        step();
        chk("rbw_old", {8'h0, bus.VGA_R, bus.VGA_G, bus.VGA_B}, 32'h010203);
        step();
        chk("rbw_new", {8'h0, bus.VGA_R, bus.VGA_G, bus.VGA_B}, 32'h0A0B0C);
        chk("rbw_new_x", 32'(bus.DrawX_out), 32'd2);

        for (int c = 0; c < 400; c++) begin
            logic [19:0] ix;
            for (int i = 0; i < 4; i++) ix[i*5 +: 5] = 5'($urandom_range(0, 9));
            drive(($urandom_range(0, 7) == 0), 10'($urandom), 10'($urandom), 4'($urandom),
                  ($urandom_range(0, 3) == 0) ? 4'($urandom) : 4'hF, ix, 5'($urandom));
            bus.pix_valid_in = ($urandom_range(0, 3) != 0);
            bus.frame_start  = ($urandom_range(0, 15) == 0);
            bus.pal_we       = ($urandom_range(0, 3) == 0);
            bus.pal_waddr    = 5'($urandom_range(0, 9));
            bus.pal_wdata    = 24'($urandom);
            step();
        end
        idle();
        pal_write(5'd5, 24'h570C0C);

        // Reset in the middle of a pixel stream, then in the middle of init
        for (int c = 0; c < 3; c++) begin
            drive(0, 10'(c), 10'd0, 4'h0, 4'hF, 20'h0, 5'd5);
            step();
        end
        rst = 1; step();
        chk("rst_stream_valid", 32'(bus.pix_valid_out), 32'd0);
        chk("rst_stream_sticky", 32'(bus.collide_sticky), 32'd0);
        rst = 0;
        busy_count(1'b0, bc);
        chk("reinit_busy_len", 32'(bc), 32'd32);
        for (int c = 0; c < 10; c++) step();
        idle();
        rst = 1; step();
        chk("rst_init_busy", 32'(bus.pal_busy), 32'd0);
        rst = 0;
        busy_count(1'b0, bc);
        chk("restart_busy_len", 32'(bc), 32'd32);
        run_pix(0, 10'd3, 10'd3, 4'h0, 4'hF, 20'h0, 5'd5);
        chk("writes_lost", {8'h0, bus.VGA_R, bus.VGA_G, bus.VGA_B}, 32'd0);
        chk("writes_lost_valid", 32'(bus.pix_valid_out), 32'd1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
